// File: rtl/hcsr04_echo_ranger_pkg.sv
// hcsr04_echo_ranger_pkg: shared constants, FSM encoding and BCD helper for the echo ranger
package hcsr04_echo_ranger_pkg;
    localparam int unsigned DATA_W = 12;
    localparam logic [DATA_W-1:0] BCD_MAX = 12'h999;
    localparam int unsigned TRIG_CYCLES = 500;
    localparam int unsigned MEAS_PERIOD_CYCLES = 3_000_000;
    localparam int unsigned TIMEOUT_CYCLES = 1_900_000;
    localparam int unsigned CM_DIV_CYCLES = 2900;
    localparam int unsigned IN_DIV_CYCLES = 7400;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_DONE = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    // Saturating packed-BCD increment: ones carry into tens, tens into hundreds, stops at 999
    function automatic logic [DATA_W-1:0] bcd_incr(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4] = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/hcsr04_echo_ranger_if.sv
// hcsr04_echo_ranger_if: sensor pins plus the result/strobe pair handed to the UART transmitter
interface hcsr04_echo_ranger_if;
    import hcsr04_echo_ranger_pkg::*;
    logic              echo;
    logic              cm_or_inch;
    logic              trig;
    logic [DATA_W-1:0] data;
    logic              data_available;

    modport master (input echo, input cm_or_inch, output trig, output data, output data_available);
    modport slave (output echo, output cm_or_inch, input trig, input data, input data_available);
endinterface

// File: rtl/hcsr04_echo_ranger_bcd_counter.sv
// hcsr04_echo_ranger_bcd_counter: 3-digit saturating packed-BCD counter, clear beats increment
module hcsr04_echo_ranger_bcd_counter
    import hcsr04_echo_ranger_pkg::*;
(
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] bcd_o
);
    logic [DATA_W-1:0] bcd_q, bcd_d;

    // Next count: clear, saturating increment or hold
    always_comb begin
        bcd_d = clr_i ? '0 : inc_i ? bcd_incr(bcd_q) : bcd_q;
    end

    // Count register
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) bcd_q <= '0;
        else          bcd_q <= bcd_d;
    end

    assign bcd_o = bcd_q;
endmodule

// File: rtl/hcsr04_echo_ranger.sv
// hcsr04_echo_ranger: triggers the HC-SR04, times the echo and reports the distance in packed BCD
module hcsr04_echo_ranger
    import hcsr04_echo_ranger_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES_P        = TRIG_CYCLES,
    parameter int unsigned MEAS_PERIOD_CYCLES_P = MEAS_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES_P     = TIMEOUT_CYCLES,
    parameter int unsigned CM_DIV_CYCLES_P      = CM_DIV_CYCLES,
    parameter int unsigned IN_DIV_CYCLES_P      = IN_DIV_CYCLES
) (
    input logic Clk_i,
    input logic Reset_i,
    hcsr04_echo_ranger_if.master bus
);
    localparam int unsigned PW = $clog2(MEAS_PERIOD_CYCLES_P);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES_P > TRIG_CYCLES_P ? TIMEOUT_CYCLES_P : TRIG_CYCLES_P);
    localparam int unsigned DW = $clog2(IN_DIV_CYCLES_P > CM_DIV_CYCLES_P ? IN_DIV_CYCLES_P : CM_DIV_CYCLES_P);

    state_t            state_q, state_d;
    logic              s1_q, s2_q, hist_q;
    logic [PW-1:0]     period_q, period_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DW-1:0]     presc_q, presc_d;
    logic              unit_q, unit_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              avail_q, avail_d;
    logic              bcd_clr, bcd_inc;
    logic [DATA_W-1:0] bcd;
    logic              rise, fall, wrap, trig_end, time_up;
    logic [DW-1:0]     div_last;

    // Both echo edges see the same synchroniser delay, so the measured width is unbiased
    assign rise     = s2_q & ~hist_q;
    assign fall     = ~s2_q & hist_q;
    assign div_last = unit_q ? DW'(IN_DIV_CYCLES_P - 1) : DW'(CM_DIV_CYCLES_P - 1);
    assign wrap     = presc_q == div_last;
    assign trig_end = timer_q == TW'(TRIG_CYCLES_P - 1);
    assign time_up  = timer_q == TW'(TIMEOUT_CYCLES_P - 1);

    // FSM state register
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; unknown encodings fall back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = S_TRIG;
            S_TRIG:  state_d = trig_end ? S_WAIT : S_TRIG;
            S_WAIT:  state_d = rise ? S_MEAS : time_up ? S_DONE : S_WAIT;
            S_MEAS:  state_d = (fall || time_up) ? S_DONE : S_MEAS;
            S_DONE:  state_d = S_HOLD;
            S_HOLD:  state_d = (period_q >= PW'(MEAS_PERIOD_CYCLES_P - 1)) ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values; the timer restarts on every state change
    always_comb begin
        period_d = (state_d == S_IDLE) ? '0 : period_q + 1'b1;
        timer_d  = (state_d != state_q) ? '0 : timer_q + 1'b1;
        presc_d  = (state_q != S_MEAS || wrap) ? '0 : presc_q + 1'b1;
        bcd_clr  = (state_q == S_WAIT) && rise;
        bcd_inc  = (state_q == S_MEAS) && wrap;
        unit_d   = (state_q == S_IDLE) ? bus.cm_or_inch : unit_q;
        err_d    = bcd_clr ? 1'b0
                 : (((state_q == S_WAIT) || (state_q == S_MEAS && !fall)) && time_up) ? 1'b1
                 : err_q;
        data_d   = (state_q == S_DONE) ? (err_q ? BCD_MAX : bcd) : data_q;
        avail_d  = state_q == S_DONE;
    end

    // Synchroniser, counters and registered outputs
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            hist_q   <= 1'b0;
            period_q <= '0;
            timer_q  <= '0;
            presc_q  <= '0;
            unit_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            avail_q  <= 1'b0;
        end else begin
            s1_q     <= bus.echo;
            s2_q     <= s1_q;
            hist_q   <= s2_q;
            period_q <= period_d;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            unit_q   <= unit_d;
            err_q    <= err_d;
            data_q   <= data_d;
            avail_q  <= avail_d;
        end
    end

    hcsr04_echo_ranger_bcd_counter u_bcd (
        .Clk_i  (Clk_i),
        .Reset_i(Reset_i),
        .clr_i  (bcd_clr),
        .inc_i  (bcd_inc),
        .bcd_o  (bcd)
    );

    assign bus.trig           = state_q == S_TRIG;
    assign bus.data           = data_q;
    assign bus.data_available = avail_q;
endmodule

// File: tb/tb_hcsr04_echo_ranger.sv
// tb_hcsr04_echo_ranger: directed vectors for the echo ranger with shortened timing parameters
module tb_hcsr04_echo_ranger;
    localparam int TRIG   = 5;
    localparam int PERIOD = 4400;
    localparam int TMO    = 2100;

    typedef struct {
        bit          unit;
        int          width;
        bit          tog;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          n_strobe = 0;
    logic [11:0] last_data = '0;

    always #5 clk = ~clk;

    hcsr04_echo_ranger_if bus();

    hcsr04_echo_ranger #(
        .TRIG_CYCLES_P(TRIG),
        .MEAS_PERIOD_CYCLES_P(PERIOD),
        .TIMEOUT_CYCLES_P(TMO),
        .CM_DIV_CYCLES_P(2),
        .IN_DIV_CYCLES_P(5)
    ) dut (
        .Clk_i(clk),
        .Reset_i(rst_n),
        .bus(bus)
    );

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.data_available === 1'b1) begin
            n_strobe = n_strobe + 1;
            last_data = bus.data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_trig_rise(output int at, output int lat, output bit ok);
        ok = 0; at = 0; lat = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (bus.trig === 1'b1) begin
                ok = 1; at = cyc; lat = k + 1;
                break;
            end
        end
    endtask

    task automatic wait_trig_fall(output int width, output bit ok);
        ok = 0; width = 1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (bus.trig !== 1'b1) begin
                ok = 1;
                break;
            end
            width++;
        end
    endtask

    task automatic wait_strobe(input int n0, output bit ok);
        ok = 0;
        for (int k = 0; k < 6000; k++) begin
            if (n_strobe > n0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse(input int width, input bit tog);
        bus.echo = 1'b1;
        for (int k = 0; k < width; k++) begin
            if (tog && k == width / 2) bus.cm_or_inch = ~bus.cm_or_inch;
            @(negedge clk);
        end
        bus.echo = 1'b0;
    endtask

    initial begin
        vec_t vec[13];
        int   t_rise, t_next, lat, tw, n0;
        bit   ok;
        vec[0]  = '{1'b0, 50,   1'b0, 12'h025};
        vec[1]  = '{1'b0, 1,    1'b0, 12'h000};
        vec[2]  = '{1'b0, 3,    1'b0, 12'h001};
        vec[3]  = '{1'b0, 20,   1'b0, 12'h010};
        vec[4]  = '{1'b0, 198,  1'b0, 12'h099};
        vec[5]  = '{1'b0, 200,  1'b0, 12'h100};
        vec[6]  = '{1'b1, 50,   1'b0, 12'h010};
        vec[7]  = '{1'b1, 50,   1'b1, 12'h010};
        vec[8]  = '{1'b1, 4,    1'b0, 12'h000};
        vec[9]  = '{1'b0, 1996, 1'b0, 12'h998};
        vec[10] = '{1'b0, 2050, 1'b0, 12'h999};
        vec[11] = '{1'b0, 0,    1'b0, 12'h999};
        vec[12] = '{1'b0, 2500, 1'b0, 12'h999};
        bus.echo = 1'b0;
        bus.cm_or_inch = vec[0].unit;
        repeat (3) @(negedge clk);
        check("reset_trig", 32'(bus.trig), 32'd0);
        check("reset_data", 32'(bus.data), 32'h000);
        check("reset_avail", 32'(bus.data_available), 32'd0);
        rst_n = 1'b1;
        wait_trig_rise(t_rise, lat, ok);
        check("first_trig_seen", 32'(ok), 32'd1);
        check("first_trig_latency", 32'(lat), 32'd1);

        for (int i = 0; i < 13; i++) begin
            n0 = n_strobe;
            wait_trig_fall(tw, ok);
            check("trig_width", 32'(tw), 32'(TRIG));
            repeat (3) @(negedge clk);
            if (vec[i].width > 0) pulse(vec[i].width, vec[i].tog);
            wait_strobe(n0, ok);
            check("strobe_seen", 32'(ok), 32'd1);
            check($sformatf("data_v%0d", i), 32'(last_data), 32'(vec[i].exp));
            bus.cm_or_inch = (i < 12) ? vec[i + 1].unit : 1'b0;
            wait_trig_rise(t_next, lat, ok);
            check("next_trig_seen", 32'(ok), 32'd1);
            check("one_strobe", 32'(n_strobe - n0), 32'd1);
            check("period", 32'(t_next - t_rise), 32'(PERIOD));
            t_rise = t_next;
        end

        // Echo already high before WAIT_ECHO: no rise, so it must time out
        n0 = n_strobe;
        bus.echo = 1'b1;
        wait_strobe(n0, ok);
        check("stuck_strobe_seen", 32'(ok), 32'd1);
        check("stuck_data", 32'(last_data), 32'h999);
        bus.echo = 1'b0;
        repeat (5) @(negedge clk);
        pulse(10, 1'b0);
        wait_trig_rise(t_next, lat, ok);
        check("stuck_next_trig", 32'(ok), 32'd1);
        check("holdoff_echo_ignored", 32'(n_strobe - n0), 32'd1);

        // Reset in the middle of a measurement
        n0 = n_strobe;
        wait_trig_fall(tw, ok);
        pulse(0, 1'b0);
        bus.echo = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_trig", 32'(bus.trig), 32'd0);
        check("midreset_data", 32'(bus.data), 32'h000);
        check("midreset_avail", 32'(bus.data_available), 32'd0);
        repeat (2) @(negedge clk);
        bus.echo = 1'b0;
        rst_n = 1'b1;
        wait_trig_rise(t_next, lat, ok);
        check("postreset_trig_latency", 32'(lat), 32'd1);
        check("postreset_no_strobe", 32'(n_strobe - n0), 32'd0);
        wait_trig_fall(tw, ok);
        repeat (3) @(negedge clk);
        pulse(50, 1'b0);
        wait_strobe(n0, ok);
        check("postreset_strobe_seen", 32'(ok), 32'd1);
        check("postreset_data", 32'(last_data), 32'h025);
        check("postreset_one_strobe", 32'(n_strobe - n0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
